matrix_display_arbiter: RTL



---
 rtl/display_pkg.sv | 30 +++
 rtl/tone_gen.sv | 31 +++
 rtl/matrix_display_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the LED matrix / buzzer arbiter.
package display_pkg;

  localparam int REQ_PLAY = 0;
  localparam int REQ_WIN  = 1;
  localparam int REQ_FAIL = 2;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_e;

  localparam logic [7:0] HANG_OFF = 8'hFF;
  localparam logic [7:0] RED_OFF  = 8'h00;

  // Row 0 lives in the top byte, so shift the wanted row down to [7:0].
  function automatic logic [7:0] frame_row(input logic [63:0] f, input logic [2:0] r);
    logic [63:0] t;
    t = f >> {~r, 3'b000};
    return t[7:0];
  endfunction

  // Fixed priority: fail face > success face > play.
  function automatic logic [2:0] pick(input logic [2:0] req);
    logic [2:0] g;
    g = '0;
    if (req[REQ_FAIL])      g[REQ_FAIL] = 1'b1;
    else if (req[REQ_WIN])  g[REQ_WIN]  = 1'b1;
    else if (req[REQ_PLAY]) g[REQ_PLAY] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every i_half cycles while enabled,
// held cleared (output low) while disabled.
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_half,
  input  logic        i_en,
  output logic        o_beep
);

  logic [15:0] r_cnt;
  logic        r_beep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (r_cnt == i_half - 16'd1) begin
      r_cnt  <= '0;
      r_beep <= ~r_beep;
    end else begin
      r_cnt  <= r_cnt + 16'd1;
    end
  end

  assign o_beep = r_beep;

endmodule

// File: rtl/matrix_display_arbiter.sv
// Time-shares the 8x8 LED matrix and buzzer between three frame sources,
// scanning rows itself and switching grants only on frame boundaries.
module matrix_display_arbiter
  import display_pkg::*;
#(
  parameter int ROW_DIV    = 1000,
  parameter int TONE_HALF0 = 500,
  parameter int TONE_HALF1 = 250,
  parameter int TONE_HALF2 = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  input  logic [2:0]  beep_en,
  output logic [2:0]  gnt,
  output logic [7:0]  hang,
  output logic [7:0]  red,
  output logic        beep,
  output logic        frame_done
);

  localparam int DIV_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROW_DIV - 1);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_gnt, r_gnt_q, w_gnt_nxt;
  logic [63:0]       r_shadow, w_frame_sel;
  logic [2:0]        r_row;
  logic [DIV_W-1:0]  r_div;
  logic [7:0]        r_hang, r_red;
  logic              r_frame_done;
  logic              w_row_end, w_frame_end, w_held, w_tone_en;
  logic [15:0]       w_half;

  assign w_row_end   = (r_div == DIV_LAST);
  assign w_frame_end = (r_state == SCAN) && w_row_end && (r_row == 3'd7);
  assign w_held      = |(req & r_gnt);
  assign w_frame_sel = r_gnt[REQ_FAIL] ? frame2 : (r_gnt[REQ_WIN] ? frame1 : frame0);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: if (|req) begin
        w_gnt_nxt   = pick(req);
        w_state_nxt = LOAD;
      end
      LOAD: w_state_nxt = SCAN;
      SCAN: begin
        // Frame boundary re-arbitrates; otherwise only a grantee drop ends the scan.
        if (w_frame_end) begin
          w_gnt_nxt   = pick(req);
          w_state_nxt = (|req) ? LOAD : IDLE;
        end else if (!w_held) begin
          w_gnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gnt_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gnt_q <= r_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_row        <= '0;
      r_div        <= '0;
      r_hang       <= HANG_OFF;
      r_red        <= RED_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      case (r_state)
        LOAD: begin
          r_shadow <= w_frame_sel;
          r_row    <= '0;
          r_div    <= '0;
          r_hang   <= ~8'h80;
          r_red    <= frame_row(w_frame_sel, 3'd0);
        end
        SCAN: begin
          if (w_state_nxt != SCAN) begin
            r_div  <= '0;
            r_hang <= HANG_OFF;
            r_red  <= RED_OFF;
          end else if (w_row_end) begin
            r_div  <= '0;
            r_row  <= r_row + 3'd1;
            r_hang <= ~(8'h80 >> (r_row + 3'd1));
            r_red  <= frame_row(r_shadow, r_row + 3'd1);
          end else begin
            r_div  <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_div  <= '0;
          r_hang <= HANG_OFF;
          r_red  <= RED_OFF;
        end
      endcase
    end
  end

  // A freshly changed grant keeps the tone cleared for one cycle.
  assign w_tone_en = (r_state != IDLE) && (|(r_gnt & beep_en)) && (r_gnt == r_gnt_q);
  assign w_half    = r_gnt[REQ_FAIL] ? 16'(TONE_HALF2) :
                     (r_gnt[REQ_WIN] ? 16'(TONE_HALF1) : 16'(TONE_HALF0));

  tone_gen u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_half (w_half),
    .i_en   (w_tone_en),
    .o_beep (beep)
  );

  assign gnt        = r_gnt;
  assign hang       = r_hang;
  assign red        = r_red;
  assign frame_done = r_frame_done;

endmodule
